mips_cpu_bus_master: RTL and testbench

- Initiator side of the CPU memory bus: turns one CPU load/store request into one bus transaction on the shared read/write/byteenable/waitrequest interface, and returns the aligned, extended result to the CPU.
- Sits between the CPU datapath (fetch/load-store stage) and the memory bus responder.
- Handles byte-lane mapping, waitrequest stalling, the 1-cycle read-data latency and misalignment detection.

---
 rtl/mips_cpu_bus_master_if.sv | 39 +++
 rtl/mips_cpu_bus_master.sv | 251 +++++++++++++++++++++++++
 tb/tb_mips_cpu_bus_master.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_bus_master_if.sv
// CPU-request / memory-bus signal bundle for mips_cpu_bus_master.
// The master modport is the bus master's view; the slave modport is the
// view of whoever plays both the CPU and the memory responder (e.g. a bench).
interface mips_cpu_bus_master_if;
  // CPU request side
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // CPU response side
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // memory bus side
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  waitrequest, readdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output address, read, write, byteenable, writedata
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output waitrequest, readdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  address, read, write, byteenable, writedata
  );
endinterface

// File: rtl/mips_cpu_bus_master.sv
// mips_cpu_bus_master: turns one CPU load/store into one bus transaction
// (read/write/byteenable/waitrequest bus, readdata one cycle after the
// accepted read) and returns the lane-selected, extended result.
//
// Handshake: a CPU request is taken on a clk edge where req_valid && req_ready;
// req_ready is high only in IDLE, so only one transaction is ever outstanding.
// On the bus a strobe is accepted on the edge where waitrequest is low; until
// then strobe, address, byteenable and writedata are held. resp_valid is a
// one-cycle pulse; resp_rdata/resp_err hold until the next response.
//
// Optional build macro: MIPS_BUS_MASTER_TIMEOUT_EN
//   defined   -> a BUS phase stalled TIMEOUT_CYCLES cycles is aborted with
//                resp_err=1 and resp_rdata=0.
//   undefined -> BUS waits on waitrequest indefinitely.
module mips_cpu_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  mips_cpu_bus_master_if.master   bus,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUS   = 2'd1,
    S_RDATA = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t      state_q, state_d;

  // request attributes latched at acceptance
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  logic        store_q, store_d;

  // registered bus outputs
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic [31:0] writedata_q, writedata_d;

  // registered response payload
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

`ifdef MIPS_BUS_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  // Abort on the edge that closes the TIMEOUT_CYCLES-th stalled cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYCLES);
`endif

  // Request decode: alignment check, lane enables and replicated store data.
  logic        req_misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wd;

  // Decode the incoming request's size/address into bus lane information.
  always_comb begin
    req_misaligned = 1'b0;
    req_be         = 4'b1111;
    req_wd         = bus.req_wdata;
    case (bus.req_size)
      SIZE_BYTE: begin
        req_be = 4'b0001 << bus.req_addr[1:0];
        req_wd = {4{bus.req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        req_misaligned = bus.req_addr[0];
        req_be         = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        req_wd         = {2{bus.req_wdata[15:0]}};
      end
      SIZE_WORD: begin
        req_misaligned = (bus.req_addr[1:0] != 2'b00);
      end
      default: begin
        // reserved size is reported as an error, never driven on the bus
        req_misaligned = 1'b1;
      end
    endcase
  end

  // Load data path: shift the addressed lane down, then extend it.
  logic [31:0] lane_data;
  logic [31:0] load_ext;

  // Select the addressed lane of readdata and sign/zero-extend it.
  always_comb begin
    // an aligned half always has lane_q[0]==0, so a byte shift covers both
    lane_data = bus.readdata >> {lane_q, 3'b000};
    load_ext  = bus.readdata;
    case (size_q)
      SIZE_BYTE: load_ext = signed_q ? {{24{lane_data[7]}}, lane_data[7:0]}
                                     : {24'h000000, lane_data[7:0]};
      SIZE_HALF: load_ext = signed_q ? {{16{lane_data[15]}}, lane_data[15:0]}
                                     : {16'h0000, lane_data[15:0]};
      default:   load_ext = bus.readdata;
    endcase
  end

  // Next-state and next-output logic of the transaction FSM.
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    signed_d     = signed_q;
    lane_d       = lane_q;
    store_d      = store_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    byteenable_d = byteenable_q;
    writedata_d  = writedata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
`ifdef MIPS_BUS_MASTER_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          lane_d   = bus.req_addr[1:0];
          store_d  = bus.req_write;
          if (req_misaligned) begin
            // report immediately; the bus never sees this request
            resp_rdata_d = 32'h0000_0000;
            resp_err_d   = 1'b1;
            state_d      = S_RESP;
          end else begin
            address_d    = {bus.req_addr[31:2], 2'b00};
            byteenable_d = req_be;
            writedata_d  = req_wd;
            read_d       = ~bus.req_write;
            write_d      = bus.req_write;
`ifdef MIPS_BUS_MASTER_TIMEOUT_EN
            tmo_d        = '0;
`endif
            state_d      = S_BUS;
          end
        end
      end

      S_BUS: begin
        if (!bus.waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (store_q) begin
            resp_rdata_d = 32'h0000_0000;
            resp_err_d   = 1'b0;
            state_d      = S_RESP;
          end else begin
            state_d = S_RDATA;
          end
        end
`ifdef MIPS_BUS_MASTER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          read_d       = 1'b0;
          write_d      = 1'b0;
          resp_rdata_d = 32'h0000_0000;
          resp_err_d   = 1'b1;
          state_d      = S_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      S_RDATA: begin
        // readdata is valid in this cycle only
        resp_rdata_d = load_ext;
        resp_err_d   = 1'b0;
        state_d      = S_RESP;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      lane_q       <= 2'b00;
      store_q      <= 1'b0;
      address_q    <= 32'h0000_0000;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      byteenable_q <= 4'b0000;
      writedata_q  <= 32'h0000_0000;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      lane_q       <= lane_d;
      store_q      <= store_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

`ifdef MIPS_BUS_MASTER_TIMEOUT_EN
  // Stall counter for the current BUS phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.byteenable = byteenable_q;
  assign bus.writedata  = writedata_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// Self-checking bench for mips_cpu_bus_master: the bench acts as CPU and as
// memory responder, and compares every response against a scoreboard queue.
module tb_mips_cpu_bus_master;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;

  // {err, rdata} expected for each request in flight
  logic [32:0] exp_q[$];

  mips_cpu_bus_master_if bus();

  mips_cpu_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn,
                                           input logic [1:0] lane, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   return sgn ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   return sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00: case (lane)
               2'd0:    return 4'b0001;
               2'd1:    return 4'b0010;
               2'd2:    return 4'b0100;
               default: return 4'b1000;
             endcase
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wd(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      2'b01:   return {wd[15:0], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_size    = 2'b00;
    bus.req_signed  = 1'b0;
    bus.req_addr    = 32'h0;
    bus.req_wdata   = 32'h0;
    bus.waitrequest = 1'b0;
    bus.readdata    = 32'h0;
  endtask

  // One request: drive it, play responder for `stalls` wait cycles, then
  // check bus signals every strobe cycle, latency and the popped expectation.
  task automatic run_txn(input string name, input logic wr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdword, input int stalls, input int exp_strobes,
                         input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
    int          cyc;
    int          stall_left;
    int          strobes;
    bit          got;
    bit          prev_acc;
    logic [32:0] exp;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    exp_addr = {addr[31:2], 2'b00};
    exp_be   = ref_be(size, addr[1:0]);
    exp_wd   = ref_wd(size, wdata);

    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready: got %b want 1", name, bus.req_ready);
    end
    bus.req_valid   = 1'b1;
    bus.req_write   = wr;
    bus.req_size    = size;
    bus.req_signed  = sgn;
    bus.req_addr    = addr;
    bus.req_wdata   = wdata;
    bus.waitrequest = 1'($urandom_range(0, 1));
    bus.readdata    = 32'h5A5A_5A5A;
    exp_q.push_back({exp_err, exp_rdata});

    got = 0; cyc = 0; prev_acc = 0; stall_left = stalls; strobes = 0;
    while (!got && cyc < 64) begin
      @(negedge clk);
      cyc++;
      // request fields become garbage once accepted
      bus.req_valid  = 1'b0;
      bus.req_addr   = $urandom();
      bus.req_wdata  = $urandom();
      bus.req_size   = 2'($urandom_range(0, 3));
      bus.req_signed = 1'($urandom_range(0, 1));
      bus.req_write  = 1'($urandom_range(0, 1));
      bus.readdata   = prev_acc ? rdword : 32'h5A5A_5A5A;
      prev_acc       = 0;
      if (bus.read === 1'b1 || bus.write === 1'b1) begin
        strobes++;
        checks++;
        if (bus.read !== ~wr || bus.write !== wr) begin
          errors++;
          $display("FAIL %s strobes: read=%b write=%b want read=%b write=%b",
                   name, bus.read, bus.write, ~wr, wr);
        end
        checks++;
        if (bus.address !== exp_addr) begin
          errors++;
          $display("FAIL %s address: got %h want %h", name, bus.address, exp_addr);
        end
        checks++;
        if (bus.byteenable !== exp_be) begin
          errors++;
          $display("FAIL %s byteenable: got %b want %b", name, bus.byteenable, exp_be);
        end
        if (wr) begin
          checks++;
          if (bus.writedata !== exp_wd) begin
            errors++;
            $display("FAIL %s writedata: got %h want %h", name, bus.writedata, exp_wd);
          end
        end
        if (stall_left > 0) begin
          bus.waitrequest = 1'b1;
          stall_left--;
        end else begin
          bus.waitrequest = 1'b0;
          prev_acc        = (bus.read === 1'b1);
        end
      end else begin
        bus.waitrequest = 1'($urandom_range(0, 1));
      end
      if (bus.resp_valid === 1'b1) got = 1;
    end

    exp = exp_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s response: none within 64 cycles, want one at cycle %0d", name, exp_lat);
    end else begin
      checks++;
      if (bus.resp_err !== exp[32]) begin
        errors++;
        $display("FAIL %s resp_err: got %b want %b", name, bus.resp_err, exp[32]);
      end
      checks++;
      if (bus.resp_rdata !== exp[31:0]) begin
        errors++;
        $display("FAIL %s resp_rdata: got %h want %h", name, bus.resp_rdata, exp[31:0]);
      end
      if (cyc != exp_lat) begin
        errors++;
        $display("FAIL %s latency: got cycle %0d want cycle %0d", name, cyc, exp_lat);
      end
    end
    checks++;
    if (strobes != exp_strobes) begin
      errors++;
      $display("FAIL %s strobe_cycles: got %0d want %0d", name, strobes, exp_strobes);
    end

    // response is a single-cycle pulse and the master is ready again
    @(negedge clk);
    bus.waitrequest = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_resp: resp_valid=%b req_ready=%b want 0/1",
               name, bus.resp_valid, bus.req_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    checks++;
    if (bus.read !== 1'b0 || bus.write !== 1'b0 || bus.byteenable !== 4'b0000 ||
        bus.address !== 32'h0 || bus.writedata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: read=%b write=%b be=%b addr=%h wd=%h want all 0",
               bus.read, bus.write, bus.byteenable, bus.address, bus.writedata);
    end
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: valid=%b rdata=%h err=%b want 0/0/0",
               bus.resp_valid, bus.resp_rdata, bus.resp_err);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_loads();
    run_txn("word_load", 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF,
            0, 1, 3, 1'b0, 32'hDEAD_BEEF);
    run_txn("sbyte_load", 1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0, 32'h8011_2233,
            0, 1, 3, 1'b0, 32'hFFFF_FF80);
    run_txn("ubyte_load", 1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0, 32'h8011_2233,
            0, 1, 3, 1'b0, 32'h0000_0080);
    run_txn("shalf_load_hi", 1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0, 32'h8001_7FFF,
            1, 2, 4, 1'b0, 32'hFFFF_8001);
    run_txn("uhalf_load_lo", 1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0, 32'h8001_F00D,
            0, 1, 3, 1'b0, 32'h0000_F00D);
  endtask

  task automatic test_stores();
    run_txn("half_store_wait3", 1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_ABCD, 32'h0,
            3, 4, 5, 1'b0, 32'h0);
    run_txn("byte_store", 1'b1, 2'b00, 1'b0, 32'h0000_0031, 32'h1234_56A5, 32'h0,
            0, 1, 2, 1'b0, 32'h0);
    run_txn("word_store", 1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'hCAFE_0123, 32'h0,
            1, 2, 3, 1'b0, 32'h0);
  endtask

  task automatic test_misaligned();
    run_txn("mis_word", 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 32'h0,
            0, 0, 1, 1'b1, 32'h0);
    run_txn("mis_half_store", 1'b1, 2'b01, 1'b0, 32'h0000_0007, 32'h1111_2222, 32'h0,
            0, 0, 1, 1'b1, 32'h0);
    run_txn("reserved_size", 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 32'h0,
            0, 0, 1, 1'b1, 32'h0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0000_0040;
    @(negedge clk);
    bus.req_valid   = 1'b0;
    bus.waitrequest = 1'b1;
    checks++;
    if (bus.read !== 1'b1) begin
      errors++;
      $display("FAIL midreset_read_before: got %b want 1", bus.read);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.read !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: read=%b resp_valid=%b want 0/0", bus.read, bus.resp_valid);
    end
    @(negedge clk);
    reset_n         = 1'b1;
    bus.waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.read !== 1'b0) begin
        errors++;
        $display("FAIL midreset_after%0d: resp_valid=%b req_ready=%b read=%b want 0/1/0",
                 i, bus.resp_valid, bus.req_ready, bus.read);
      end
    end
  endtask

`ifdef MIPS_BUS_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    run_txn("timeout_read", 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 32'h1234_5678,
            100, 4, 5, 1'b1, 32'h0);
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      logic [1:0]  size;
      logic [1:0]  lane;
      logic        sgn;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] word;
      logic [31:0] wd;
      int          stalls;
      size   = 2'($urandom_range(0, 2));
      lane   = 2'($urandom_range(0, 3));
      if (size == 2'b01) lane[0] = 1'b0;
      if (size == 2'b10) lane = 2'b00;
      sgn    = 1'($urandom_range(0, 1));
      wr     = 1'($urandom_range(0, 1));
      addr   = {$urandom() & 32'hFFFF_FFFC} | {30'h0, lane};
      word   = $urandom();
      wd     = $urandom();
      stalls = $urandom_range(0, 2);
      run_txn($sformatf("b2b_%0d", i), wr, size, sgn, addr, wd, word, stalls, stalls + 1,
              wr ? (2 + stalls) : (3 + stalls), 1'b0,
              wr ? 32'h0 : ref_load(size, sgn, lane, word));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_reset_mid();
`ifdef MIPS_BUS_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
